pwm_duty_sequencer: RTL and testbench
=====================================

# pwm_duty_sequencer

Controller for the PWM controller's duty-cycle datapath. It conditions the raw `increase_duty` / `decrease_duty` buttons with a synchronizer, debouncer and optional auto-repeat, and keeps a saturating target duty. It transfers the target duty into the PWM generator only at period boundaries, so `pwm_out` never glitches mid-period. It sits between the pad inputs and the top-level `PWM_OUT` pin.

## Interface
Parameters:
- `DUTY_MAX`, 10: counts per PWM period and the maximum duty value (100%).
- `DUTY_RESET`, 5: duty loaded at reset; must be ≤ `DUTY_MAX`.
- `STEP`, 1: duty increment/decrement per press event; must be ≥ 1.
- `DB_CYCLES`, 4: consecutive stable synchronized samples required to change a filtered button level.
- `REPEAT_DELAY`, 40: cycles from the initial press event to the first repeat event.
- `REPEAT_RATE`, 20: cycles between subsequent repeat events.

Ports (`DW = $clog2(DUTY_MAX+1)`):
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `increase_duty`  in  1  raw, asynchronous, bouncy button.
- `decrease_duty`  in  1  raw, asynchronous, bouncy button.
- `duty_tgt`  out  DW  target duty, updated by press events.
- `duty_act`  out  DW  duty currently applied to the PWM generator.
- `duty_upd`  out  1  one-cycle pulse when `duty_act` loads a value different from its previous value.
- `at_max`  out  1  `duty_tgt == DUTY_MAX`.
- `at_min`  out  1  `duty_tgt == 0`.
- `pwm_out`  out  1  registered PWM output.

## Operation
- **Reset** (asynchronous, immediate):
  - Synchronizers, filtered levels and debounce counters cleared.
  - Repeat FSM in IDLE.
  - `cnt = 0`; `duty_tgt = duty_act = DUTY_RESET`.
  - `pwm_out = 0`, `duty_upd = 0`.
  - `at_max` / `at_min` follow the reset value of `duty_tgt`.
- **Synchronizer:** two flops per button.
- **Debounce:**
  - A per-button counter increments while the synchronized value differs from the filtered level.
  - On reaching `DB_CYCLES`, the filtered level takes the synchronized value.
  - Any sample equal to the filtered level clears the counter.
- **Press event:** a one-cycle event on each rising edge of a filtered level, plus repeat events.
  - If both filtered levels are high, all events from both buttons are suppressed and the repeat FSM is held in IDLE.
- **Target update** (cycle after an event):
  - Increase: `duty_tgt = min(duty_tgt + STEP, DUTY_MAX)`.
  - Decrease: `duty_tgt = max(duty_tgt - STEP, 0)`.
  - Saturation is silent; arithmetic is done at DW+1 bits to avoid wrap.
- **Period counter:** `cnt` counts 0..`DUTY_MAX-1` and wraps to 0.
  - When `cnt == DUTY_MAX-1`, `duty_act <= duty_tgt`, effective from `cnt == 0`.
  - A target changed mid-period takes effect at the next period start only.
- **PWM output:** `pwm_out <= (cnt < duty_act)`.
  - Duty 0 gives a constant low; duty `DUTY_MAX` gives a constant high.

## Timing
- Raw edge sampled at cycle N (input stable from then on):
  - Filtered level rises at N+2+`DB_CYCLES`.
  - Press event in that same cycle.
  - `duty_tgt` updated at N+3+`DB_CYCLES`.
- `duty_act` lags `duty_tgt` by 1..`DUTY_MAX` cycles.
- `duty_upd` asserts in the cycle `duty_act` changes.
- `pwm_out` is one register after `cnt` / `duty_act`.
- **Reset mid-period:** all outputs take their reset values immediately; counting resumes from `cnt = 0` on the first edge after deassertion.

## Configuration
- `PWM_AUTO_REPEAT_EN` **defined** (repeat FSM compiled in):
  - States IDLE → HOLD on a press event; HOLD → REPEAT after `REPEAT_DELAY` cycles, emitting an event.
  - REPEAT emits an event every `REPEAT_RATE` cycles.
  - Any state → IDLE when the pressed button's filtered level falls, or when both buttons are high.
- `PWM_AUTO_REPEAT_EN` **undefined:** exactly one event per press; the FSM and its counters are absent.

## Structure
- Shared package `pwm_pkg`:
  - Default parameter constants.
  - `typedef enum {IDLE, HOLD, REPEAT} rpt_state_t`.
- One sub-module, `button_debouncer` (synchronizer + debounce + rising-edge detect), instantiated twice.
- Target logic, repeat FSM, period counter and PWM compare live in `pwm_duty_sequencer`.

## Test plan
All scenarios use default parameters, clock period 10 ns.
- **Reset:** assert `reset` → `duty_tgt = duty_act = 5`, `pwm_out` high exactly 5 of every 10 cycles after release.
- **Clean presses:** three `increase_duty` presses (10 cycles high, 10 low each) → `duty_tgt` steps 6, 7, 8; each `duty_act` change occurs only at a `cnt` wrap, with one `duty_upd` pulse per change.
- **Bounce:** 16 one-cycle toggles of `increase_duty`, then low → no event, `duty_tgt` stays unchanged.
- **Saturation:** from 8, five increase presses → 10, `at_max = 1`, `pwm_out` constantly high. From 0, a decrease press → stays 0, `at_min = 1`, `pwm_out` constantly low.
- **Hold** `increase_duty` for 90 cycles from 5:
  - With `PWM_AUTO_REPEAT_EN`: events at cycles 6, 46, 66, 86 → `duty_tgt = 9`.
  - Without it: one event → `duty_tgt = 6`.
- **Simultaneous / reset:** both buttons held 50 cycles → no change. Assert `reset` at `cnt = 3` with `pwm_out = 1` → `pwm_out = 0` immediately, duty back to 5.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM duty sequencer.
// The optional auto-repeat FSM is compiled in only when PWM_AUTO_REPEAT_EN is defined.
package pwm_pkg;

  localparam int unsigned DUTY_MAX_DEF     = 10;
  localparam int unsigned DUTY_RESET_DEF   = 5;
  localparam int unsigned STEP_DEF         = 1;
  localparam int unsigned DB_CYCLES_DEF    = 4;
  localparam int unsigned REPEAT_DELAY_DEF = 40;
  localparam int unsigned REPEAT_RATE_DEF  = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Larger of two constants, used to size shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, counter-based debouncer and rising-edge press detector
// for one raw button input.
module button_debouncer
  import pwm_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] db_cnt;

  // Synchronize, then accept a new level only after it has been stable long enough.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DB_CYCLES)) begin
        level  <= sync2;
        db_cnt <= '0;
        press  <= sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Button-driven duty control with period-aligned duty transfer into a PWM generator.
// Define PWM_AUTO_REPEAT_EN to compile in the press-and-hold auto-repeat FSM.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter  int unsigned DUTY_MAX     = DUTY_MAX_DEF,
  parameter  int unsigned DUTY_RESET   = DUTY_RESET_DEF,
  parameter  int unsigned STEP         = STEP_DEF,
  parameter  int unsigned DB_CYCLES    = DB_CYCLES_DEF,
  parameter  int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
  parameter  int unsigned REPEAT_RATE  = REPEAT_RATE_DEF,
  localparam int unsigned DW           = $clog2(DUTY_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          increase_duty,
  input  logic          decrease_duty,
  output logic [DW-1:0] duty_tgt,
  output logic [DW-1:0] duty_act,
  output logic          duty_upd,
  output logic          at_max,
  output logic          at_min,
  output logic          pwm_out
);

  localparam int unsigned CW = (DUTY_MAX > 1) ? $clog2(DUTY_MAX) : 1;

  logic          lvl_inc;
  logic          prs_inc;
  logic          lvl_dec;
  logic          prs_dec;
  logic          both_c;
  logic          ev_inc_c;
  logic          ev_dec_c;
  logic [DW:0]   sum_c;
  logic [DW-1:0] tgt_nxt_c;
  logic [CW-1:0] cnt;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
    .clk   (clk),
    .reset (reset),
    .btn   (increase_duty),
    .level (lvl_inc),
    .press (prs_inc)
  );

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_dec (
    .clk   (clk),
    .reset (reset),
    .btn   (decrease_duty),
    .level (lvl_dec),
    .press (prs_dec)
  );

  assign both_c = lvl_inc & lvl_dec;

`ifdef PWM_AUTO_REPEAT_EN
  localparam int unsigned RW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);

  rpt_state_t    state;
  rpt_state_t    state_nxt;
  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_cnt_nxt;
  logic          rpt_dir;
  logic          rpt_dir_nxt;
  logic          rpt_ev_c;
  logic          held_c;

  // Repeat FSM state register; rpt_dir = 1 while tracking the increase button.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rpt_cnt <= '0;
      rpt_dir <= 1'b0;
    end else begin
      state   <= state_nxt;
      rpt_cnt <= rpt_cnt_nxt;
      rpt_dir <= rpt_dir_nxt;
    end
  end

  // Repeat FSM next state: initial delay, then periodic repeat events while held.
  always_comb begin
    state_nxt   = state;
    rpt_cnt_nxt = rpt_cnt;
    rpt_dir_nxt = rpt_dir;
    rpt_ev_c    = 1'b0;
    held_c      = rpt_dir ? lvl_inc : lvl_dec;
    if (both_c) begin
      state_nxt   = IDLE;
      rpt_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (prs_inc || prs_dec) begin
            state_nxt   = HOLD;
            rpt_cnt_nxt = RW'(1);
            rpt_dir_nxt = prs_inc;
          end
        end
        HOLD: begin
          if (!held_c) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end else if (rpt_cnt == RW'(REPEAT_DELAY)) begin
            rpt_ev_c    = 1'b1;
            state_nxt   = REPEAT;
            rpt_cnt_nxt = RW'(1);
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!held_c) begin
            state_nxt   = IDLE;
            rpt_cnt_nxt = '0;
          end else if (rpt_cnt == RW'(REPEAT_RATE)) begin
            rpt_ev_c    = 1'b1;
            rpt_cnt_nxt = RW'(1);
          end else begin
            rpt_cnt_nxt = rpt_cnt + 1'b1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          rpt_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign ev_inc_c = ~both_c & (prs_inc | (rpt_ev_c &  rpt_dir));
  assign ev_dec_c = ~both_c & (prs_dec | (rpt_ev_c & ~rpt_dir));
`else
  assign ev_inc_c = ~both_c & prs_inc;
  assign ev_dec_c = ~both_c & prs_dec;
`endif

  // Saturating target update, computed one bit wider than the duty to avoid wrap.
  always_comb begin
    sum_c     = {1'b0, duty_tgt} + (DW+1)'(STEP);
    tgt_nxt_c = duty_tgt;
    if (ev_inc_c) begin
      tgt_nxt_c = (sum_c > (DW+1)'(DUTY_MAX)) ? DW'(DUTY_MAX) : sum_c[DW-1:0];
    end else if (ev_dec_c) begin
      tgt_nxt_c = ({1'b0, duty_tgt} < (DW+1)'(STEP)) ? '0
                : DW'({1'b0, duty_tgt} - (DW+1)'(STEP));
    end
  end

  // Target register with registered limit flags tracking its next value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      duty_tgt <= DW'(DUTY_RESET);
      at_max   <= (DUTY_RESET == DUTY_MAX);
      at_min   <= (DUTY_RESET == 0);
    end else begin
      duty_tgt <= tgt_nxt_c;
      at_max   <= (tgt_nxt_c == DW'(DUTY_MAX));
      at_min   <= (tgt_nxt_c == '0);
    end
  end

  // Period counter, period-boundary duty transfer and PWM compare.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      duty_act <= DW'(DUTY_RESET);
      duty_upd <= 1'b0;
      pwm_out  <= 1'b0;
    end else begin
      duty_upd <= 1'b0;
      pwm_out  <= (DW'(cnt) < duty_act);
      if (cnt == CW'(DUTY_MAX - 1)) begin
        cnt      <= '0;
        duty_act <= duty_tgt;
        duty_upd <= (duty_tgt != duty_act);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer with default parameters, 10 ns clock.
module tb_pwm_duty_sequencer;

  localparam int unsigned DW = 4;

  logic          clk;
  logic          reset;
  logic          increase_duty;
  logic          decrease_duty;
  logic [DW-1:0] duty_tgt;
  logic [DW-1:0] duty_act;
  logic          duty_upd;
  logic          at_max;
  logic          at_min;
  logic          pwm_out;

  int            n_tests;
  int            n_fail;
  int            upd_seen;
  int            pcount;
  logic [DW-1:0] prev_act;
  int            tb_cnt;

  pwm_duty_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .increase_duty (increase_duty),
    .decrease_duty (decrease_duty),
    .duty_tgt      (duty_tgt),
    .duty_act      (duty_act),
    .duty_upd      (duty_upd),
    .at_max        (at_max),
    .at_min        (at_min),
    .pwm_out       (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected position in the 10-count PWM period.
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cnt <= 0;
    else       tb_cnt <= (tb_cnt == 9) ? 0 : tb_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n cycles; any duty_act change must come with duty_upd at a period start.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (!reset && (duty_act !== prev_act || duty_upd !== 1'b0)) begin
        check("upd_pulse", 32'(duty_upd), 32'(1));
        check("upd_changed", 32'(duty_act !== prev_act), 32'(1));
        check("upd_at_wrap", 32'(tb_cnt), 32'(0));
        if (duty_upd === 1'b1) upd_seen++;
      end
      prev_act = duty_act;
    end
  endtask

  task automatic count_pwm(output int c);
    c = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pwm_out === 1'b1) c++;
    end
  endtask

  task automatic press_inc();
    increase_duty = 1'b1;
    tick(10);
    increase_duty = 1'b0;
    tick(10);
  endtask

  task automatic press_dec();
    decrease_duty = 1'b1;
    tick(10);
    decrease_duty = 1'b0;
    tick(10);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    tick(2);
    reset = 1'b0;
    prev_act = duty_act;
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    upd_seen      = 0;
    reset         = 1'b1;
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    prev_act      = '0;
    #1;
    check("rst_tgt", 32'(duty_tgt), 32'(5));
    check("rst_act", 32'(duty_act), 32'(5));
    check("rst_pwm", 32'(pwm_out), 32'(0));
    check("rst_upd", 32'(duty_upd), 32'(0));
    check("rst_at_max", 32'(at_max), 32'(0));
    check("rst_at_min", 32'(at_min), 32'(0));
    tick(2);
    reset    = 1'b0;
    prev_act = duty_act;

    tick(3);
    count_pwm(pcount);
    check("pwm_duty5", 32'(pcount), 32'(5));

    // Clean presses: 5 -> 6 -> 7 -> 8, one update pulse per change.
    upd_seen = 0;
    press_inc();
    check("press1_tgt", 32'(duty_tgt), 32'(6));
    press_inc();
    check("press2_tgt", 32'(duty_tgt), 32'(7));
    press_inc();
    check("press3_tgt", 32'(duty_tgt), 32'(8));
    tick(12);
    check("press_act", 32'(duty_act), 32'(8));
    check("press_upd_count", 32'(upd_seen), 32'(3));
    count_pwm(pcount);
    check("pwm_duty8", 32'(pcount), 32'(8));

    // Bounce: one-cycle toggles never settle.
    for (int i = 0; i < 16; i++) begin
      increase_duty = ~increase_duty;
      tick(1);
    end
    increase_duty = 1'b0;
    tick(20);
    check("bounce_tgt", 32'(duty_tgt), 32'(8));

    // Upper saturation.
    for (int i = 0; i < 5; i++) press_inc();
    check("sat_hi_tgt", 32'(duty_tgt), 32'(10));
    check("sat_hi_at_max", 32'(at_max), 32'(1));
    tick(12);
    check("sat_hi_act", 32'(duty_act), 32'(10));
    count_pwm(pcount);
    check("pwm_duty10", 32'(pcount), 32'(10));

    // Down to zero, then one more decrease.
    for (int i = 0; i < 10; i++) press_dec();
    check("zero_tgt", 32'(duty_tgt), 32'(0));
    press_dec();
    check("sat_lo_tgt", 32'(duty_tgt), 32'(0));
    check("sat_lo_at_min", 32'(at_min), 32'(1));
    check("sat_lo_at_max", 32'(at_max), 32'(0));
    tick(12);
    check("sat_lo_act", 32'(duty_act), 32'(0));
    count_pwm(pcount);
    check("pwm_duty0", 32'(pcount), 32'(0));

    // Hold increase for 90 cycles from 5.
    do_reset();
    check("hold_start_tgt", 32'(duty_tgt), 32'(5));
    increase_duty = 1'b1;
    tick(50);
`ifdef PWM_AUTO_REPEAT_EN
    check("hold_mid_tgt", 32'(duty_tgt), 32'(7));
`else
    check("hold_mid_tgt", 32'(duty_tgt), 32'(6));
`endif
    tick(40);
    increase_duty = 1'b0;
    tick(30);
`ifdef PWM_AUTO_REPEAT_EN
    check("hold_end_tgt", 32'(duty_tgt), 32'(9));
`else
    check("hold_end_tgt", 32'(duty_tgt), 32'(6));
`endif

    // Both buttons held: no change.
    increase_duty = 1'b1;
    decrease_duty = 1'b1;
    tick(50);
    increase_duty = 1'b0;
    decrease_duty = 1'b0;
    tick(20);
`ifdef PWM_AUTO_REPEAT_EN
    check("both_tgt", 32'(duty_tgt), 32'(9));
`else
    check("both_tgt", 32'(duty_tgt), 32'(6));
`endif

    // Reset mid-period while pwm_out is high.
    for (int i = 0; i < 12 && tb_cnt != 3; i++) tick(1);
    check("rst_mid_cnt", 32'(tb_cnt), 32'(3));
    check("rst_mid_pwm_pre", 32'(pwm_out), 32'(1));
    reset = 1'b1;
    #1;
    check("rst_mid_pwm", 32'(pwm_out), 32'(0));
    check("rst_mid_tgt", 32'(duty_tgt), 32'(5));
    check("rst_mid_act", 32'(duty_act), 32'(5));
    check("rst_mid_upd", 32'(duty_upd), 32'(0));
    tick(2);
    reset    = 1'b0;
    prev_act = duty_act;
    tick(1);
    count_pwm(pcount);
    check("rst_mid_pwm_duty", 32'(pcount), 32'(5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
